// File: rtl/clamp_rr_scheduler_pkg.sv
// Shared ALU definitions for the clamp scheduler: default widths, reset
// bounds, signed data type and output-register state encoding.
package clamp_rr_scheduler_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  localparam logic [31:0] CLAMP_LO_RST = 32'h0000_0000;
  localparam logic [31:0] CLAMP_HI_RST = 32'h7FFF_FFFF;

  typedef logic signed [DEF_DATA_W-1:0] data_t;

  // Occupancy of the single result register
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/clamp_rr_scheduler_if.sv
// Request/config/result bus of the clamp scheduler. The master side issues
// requests and bound writes; the slave side is the scheduler itself.
interface clamp_rr_scheduler_if
  import clamp_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = 2
) ();

  logic                      cfg_we;
  logic [ID_W-1:0]           cfg_id;
  logic [DATA_W-1:0]         cfg_lo;
  logic [DATA_W-1:0]         cfg_hi;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_sat;
  logic                      out_ready;

  modport master (
    output cfg_we, cfg_id, cfg_lo, cfg_hi, req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_sat
  );

  modport slave (
    input  cfg_we, cfg_id, cfg_lo, cfg_hi, req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_sat
  );

endinterface

// File: rtl/clamp_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request strictly after the
// pointer, wrapping around, so the last winner has the lowest priority.
module rr_arbiter
  import clamp_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] cand;
  logic            found;

  // Scan ptr+1 .. ptr+NUM_REQ; index arithmetic wraps since NUM_REQ is 2^ID_W
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + ID_W'(k);
      if (en && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clamp_rr_scheduler.sv
// Shared signed clamp datapath arbitrated round-robin between NUM_REQ
// requesters, each with its own programmable bound pair. Results leave
// through a single registered valid/ready stage; clamp events are counted.
module clamp_rr_scheduler
  import clamp_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = 2,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  clamp_rr_scheduler_if.slave     bus,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        sat_cnt
);

  out_state_t               state_q, state_d;
  logic [ID_W-1:0]          ptr_q;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_idx;
  logic                     free;
  logic                     accept;

  logic signed [DATA_W-1:0] lo_q [NUM_REQ];
  logic signed [DATA_W-1:0] hi_q [NUM_REQ];

  logic signed [DATA_W-1:0] in_sel, lo_sel, hi_sel, clamp_val;
  logic                     clamp_sat;

  logic [DATA_W-1:0]        out_data_q;
  logic [ID_W-1:0]          out_id_q;
  logic                     out_sat_q;
  logic [CNT_W-1:0]         cnt_q;

  assign free = (state_q == ST_EMPTY) || bus.out_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .en        (free),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign accept        = |gnt;
  assign bus.req_ready = gnt;

  // Select the granted operand and bounds; lower bound is tested first
  always_comb begin
    in_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) in_sel = bus.req_data[i*DATA_W +: DATA_W];
    end
    lo_sel    = lo_q[gnt_idx];
    hi_sel    = hi_q[gnt_idx];
    clamp_val = in_sel;
    clamp_sat = 1'b0;
    if (in_sel < lo_sel) begin
      clamp_val = lo_sel;
      clamp_sat = 1'b1;
    end else if (in_sel > hi_sel) begin
      clamp_val = hi_sel;
      clamp_sat = 1'b1;
    end
  end

  // Result register occupancy: fill on accept, empty on drain without refill
  always_comb begin
    state_d = state_q;
    if (accept)             state_d = ST_FULL;
    else if (bus.out_ready) state_d = ST_EMPTY;
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Result payload and RR pointer; payload holds across a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= ID_W'(NUM_REQ - 1);
      out_data_q <= '0;
      out_id_q   <= '0;
      out_sat_q  <= 1'b0;
    end else if (accept) begin
      ptr_q      <= gnt_idx;
      out_data_q <= clamp_val;
      out_id_q   <= gnt_idx;
      out_sat_q  <= clamp_sat;
    end
  end

  // Per-requester bounds; a same-cycle accept already sampled the old values
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        lo_q[i] <= DATA_W'(CLAMP_LO_RST);
        hi_q[i] <= DATA_W'(CLAMP_HI_RST);
      end
    end else if (bus.cfg_we) begin
      lo_q[bus.cfg_id] <= bus.cfg_lo;
      hi_q[bus.cfg_id] <= bus.cfg_hi;
    end
  end

  // Saturating clamp-event counter; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) cnt_q <= '0;
    else if (accept && clamp_sat && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_cnt       = cnt_q;

endmodule

// File: tb/tb_clamp_rr_scheduler.sv
// Testbench for clamp_rr_scheduler: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a behavioural model.
module tb_clamp_rr_scheduler;
  import clamp_rr_scheduler_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] sat_cnt;

  clamp_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus_if ();

  clamp_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .clr_cnt (clr_cnt),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus shadows
  logic [NUM_REQ-1:0] rv = '0;
  int                 rd [NUM_REQ];
  bit                 cw = 1'b0;
  int                 cid = 0;
  int                 clo = 0;
  int                 chi = 0;
  bit                 ordy = 1'b1;
  bit                 clr = 1'b0;

  // behavioural model state
  int m_lo [NUM_REQ];
  int m_hi [NUM_REQ];
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_id;
  bit m_sat;
  int m_cnt;

  typedef struct {
    bit do_cfg;
    int cfg_id;
    int lo;
    int hi;
    int id;
    int data;
    int exp_data;
    bit exp_sat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input data_t x, input data_t lo, input data_t hi, output bit s);
    s = 1'b0;
    if (x < lo) begin s = 1'b1; return lo; end
    if (x > hi) begin s = 1'b1; return hi; end
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_lo[i] = int'(CLAMP_LO_RST);
      m_hi[i] = int'(CLAMP_HI_RST);
    end
    m_ptr = NUM_REQ - 1;
    m_valid = 1'b0;
    m_data = 0;
    m_id = 0;
    m_sat = 1'b0;
    m_cnt = 0;
  endfunction

  // first valid requester after the last winner, none while the result is stuck
  function automatic int model_grant();
    if (m_valid && !ordy) return -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (rv[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic drive();
    bus_if.req_valid = rv;
    for (int i = 0; i < NUM_REQ; i++) bus_if.req_data[i*DATA_W +: DATA_W] = rd[i];
    bus_if.cfg_we    = cw;
    bus_if.cfg_id    = ID_W'(cid);
    bus_if.cfg_lo    = clo;
    bus_if.cfg_hi    = chi;
    bus_if.out_ready = ordy;
    clr_cnt          = clr;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  bus_if.out_data,       m_data);
    chk({tag, ".out_id"},    32'(bus_if.out_id),    m_id);
    chk({tag, ".out_sat"},   32'(bus_if.out_sat),   32'(m_sat));
    chk({tag, ".sat_cnt"},   32'(sat_cnt),          m_cnt);
  endtask

  // one clock: check grant before the edge, advance model, check registers after
  task automatic run_cycle();
    int g;
    int r;
    bit s;
    s = 1'b0;
    drive();
    #1;
    g = model_grant();
    chk("req_ready", 32'(bus_if.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        r = clampf(rd[g], m_lo[g], m_hi[g], s);
        m_data = r; m_id = g; m_sat = s; m_valid = 1'b1; m_ptr = g;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (cw) begin m_lo[cid] = clo; m_hi[cid] = chi; end
      if (clr) m_cnt = 0;
      else if (g >= 0 && s && m_cnt < CNT_MAX) m_cnt++;
    end
    check_outs("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; cw = 1'b0; clr = 1'b0; ordy = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outs("reset");
    chk("reset.out_valid_const", 32'(bus_if.out_valid), 32'd0);
    chk("reset.sat_cnt_const",   32'(sat_cnt),          32'd0);
    rst = 1'b0;
  endtask

  function automatic int pick_data(input int i);
    case ($urandom_range(0, 5))
      0:       return m_lo[i];
      1:       return m_hi[i];
      2:       return m_lo[i] - 1;
      3:       return m_hi[i] + 1;
      4:       return int'($urandom);
      default: return int'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NUM_REQ; i++) rd[i] = 0;
    model_reset();

    tbl[0]  = '{0, 0, 0,    0,   0, int'(32'h8000_0000), 0,                   1};
    tbl[1]  = '{0, 0, 0,    0,   0, int'(32'h1234_5678), int'(32'h1234_5678), 0};
    tbl[2]  = '{1, 2, -100, 100, 2, -500,                -100,                1};
    tbl[3]  = '{0, 0, 0,    0,   2, 50,                  50,                  0};
    tbl[4]  = '{0, 0, 0,    0,   2, 100,                 100,                 0};
    tbl[5]  = '{0, 0, 0,    0,   2, 101,                 100,                 1};
    tbl[6]  = '{0, 0, 0,    0,   2, -100,                -100,                0};
    tbl[7]  = '{0, 0, 0,    0,   2, -101,                -100,                1};
    tbl[8]  = '{1, 1, 10,   5,   1, 7,                   10,                  1};
    tbl[9]  = '{0, 0, 0,    0,   1, 20,                  5,                   1};
    tbl[10] = '{0, 0, 0,    0,   3, int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF), 0};
    tbl[11] = '{0, 0, 0,    0,   3, -1,                  0,                   1};

    do_reset();

    // vector table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_cfg) begin
        cw = 1'b1; cid = tbl[i].cfg_id; clo = tbl[i].lo; chi = tbl[i].hi; rv = '0;
        run_cycle();
        cw = 1'b0;
      end
      rv = '0;
      rv[tbl[i].id] = 1'b1;
      rd[tbl[i].id] = tbl[i].data;
      run_cycle();
      rv = '0;
      chk($sformatf("vec%0d.data", i), bus_if.out_data,     tbl[i].exp_data);
      chk($sformatf("vec%0d.sat", i),  32'(bus_if.out_sat), 32'(tbl[i].exp_sat));
      chk($sformatf("vec%0d.id", i),   32'(bus_if.out_id),  tbl[i].id);
      chk($sformatf("vec%0d.valid", i), 32'(bus_if.out_valid), 32'd1);
      if (i == 0) chk("vec0.sat_cnt", 32'(sat_cnt), 32'd1);
    end

    // bound write in the same cycle as a request: old bounds (-100..100) apply
    cw = 1'b1; cid = 2; clo = -10; chi = 10;
    rv = 4'b0100; rd[2] = 50;
    run_cycle();
    chk("samecyc.old_data", bus_if.out_data, 50);
    chk("samecyc.old_sat",  32'(bus_if.out_sat), 32'd0);
    cw = 1'b0;
    run_cycle();
    chk("samecyc.new_data", bus_if.out_data, 10);
    chk("samecyc.new_sat",  32'(bus_if.out_sat), 32'd1);
    rv = '0;
    run_cycle();

    // round robin from reset pointer
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rd[i] = i * 100;
    rv = 4'hF; ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      chk($sformatf("rr.id%0d", i), 32'(bus_if.out_id), i % NUM_REQ);
    end

    // backpressure: result frozen, no grants, then resume at pointer+1
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      chk("bp.req_ready", 32'(bus_if.req_ready), 32'd0);
      chk("bp.out_id",    32'(bus_if.out_id),    32'd3);
      chk("bp.out_data",  bus_if.out_data,       300);
      chk("bp.out_valid", 32'(bus_if.out_valid), 32'd1);
    end
    ordy = 1'b1;
    run_cycle();
    chk("bp.resume_id", 32'(bus_if.out_id), 32'd0);

    // reset while a result is pending and requests are active
    run_cycle();
    rst = 1'b1;
    run_cycle();
    chk("rstmid.out_valid", 32'(bus_if.out_valid), 32'd0);
    rst = 1'b0;
    drive();
    #1;
    chk("rstmid.req_ready", 32'(bus_if.req_ready), 32'd1);
    rv = 4'b0001; rd[0] = int'(32'h8000_0000);
    run_cycle();
    chk("rstmid.bound_data", bus_if.out_data, 32'd0);
    chk("rstmid.bound_sat",  32'(bus_if.out_sat), 32'd1);

    // clear together with a saturating accept
    clr = 1'b1;
    run_cycle();
    chk("cnt.clr_prio", 32'(sat_cnt), 32'd0);
    clr = 1'b0;

    // counter saturation
    for (int i = 0; i < 65536; i++) run_cycle();
    chk("cnt.max", 32'(sat_cnt), 32'h0000_FFFF);
    run_cycle();
    chk("cnt.stick", 32'(sat_cnt), 32'h0000_FFFF);
    clr = 1'b1;
    run_cycle();
    chk("cnt.clr_at_max", 32'(sat_cnt), 32'd0);
    clr = 1'b0;
    rv = '0;
    run_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rv = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) rd[i] = pick_data(i);
      ordy = ($urandom_range(0, 3) != 0);
      cw   = ($urandom_range(0, 9) == 0);
      cid  = int'($urandom_range(0, NUM_REQ - 1));
      clo  = int'($urandom_range(0, 400)) - 200;
      chi  = int'($urandom_range(0, 400)) - 200;
      clr  = ($urandom_range(0, 31) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    rst = 1'b0; cw = 1'b0; clr = 1'b0; rv = '0;
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
